// File: rtl/ysyx_22041071_lsu_pkg.sv
`default_nettype none
// =====================================================================
// ysyx_22041071_lsu_pkg -- shared funct3 codes, FSM states, base addr
// Rev 1.0
// =====================================================================
package ysyx_22041071_lsu_pkg;

   localparam logic [63:0] LSU_MEM_BASE = 64'h8000_0000;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_t;

   // Doubleword and unsigned-word accesses do not exist on a 32-bit datapath.
   function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] addr_lo,
                                           input logic       xlen64);
      logic [2:0] low_mask;
      case (funct3[1:0])
         2'd0:    low_mask = 3'b000;
         2'd1:    low_mask = 3'b001;
         2'd2:    low_mask = 3'b011;
         default: low_mask = 3'b111;
      endcase
      return (|(addr_lo & low_mask)) ||
             (!xlen64 && ((funct3[1:0] == 2'd3) || (funct3 == F3_LWU)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041071_lsu_align.sv
`default_nettype none
// =====================================================================
// ysyx_22041071_lsu_align -- byte-lane shift, strobes, load extension
// Rev 1.0
// =====================================================================
module ysyx_22041071_lsu_align
   import ysyx_22041071_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]                  funct3,
   input  logic [$clog2(XLEN/8)-1:0]   lane_raw,
   input  logic [XLEN-1:0]             wdata,
   input  logic [XLEN-1:0]             rdata,
   output logic [XLEN/8-1:0]           wstrb,
   output logic [XLEN-1:0]             wdata_out,
   output logic [XLEN-1:0]             rdata_out
);
   localparam int NB = XLEN / 8;
   localparam int LW = $clog2(NB);

   logic [1:0]      size_log2;
   logic [LW-1:0]   low_bits;
   logic [LW-1:0]   lane;
   logic [NB-1:0]   size_mask;
   logic [XLEN-1:0] shifted;

   always_comb begin
      size_log2 = funct3[1:0];
      if (XLEN == 32 && size_log2 == 2'd3) size_log2 = 2'd2;

      size_mask = NB'(8'h01);
      case (size_log2)
         2'd0: size_mask = NB'(8'h01);
         2'd1: size_mask = NB'(8'h03);
         2'd2: size_mask = NB'(8'h0F);
         2'd3: size_mask = NB'(8'hFF);
      endcase

      // Misaligned addresses are rounded down to the access size.
      low_bits  = LW'((4'd1 << size_log2) - 4'd1);
      lane      = lane_raw & ~low_bits;

      wstrb     = size_mask << lane;
      wdata_out = wdata << {lane, 3'b000};
      shifted   = rdata >> {lane, 3'b000};

      case (funct3)
         F3_LB:   rdata_out = XLEN'(signed'(shifted[7:0]));
         F3_LH:   rdata_out = XLEN'(signed'(shifted[15:0]));
         F3_LW:   rdata_out = XLEN'(signed'(shifted[31:0]));
         F3_LBU:  rdata_out = XLEN'(shifted[7:0]);
         F3_LHU:  rdata_out = XLEN'(shifted[15:0]);
         F3_LWU:  rdata_out = XLEN'(shifted[31:0]);
         default: rdata_out = shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_22041071_lsu.sv
`default_nettype none
// =====================================================================
// ysyx_22041071_lsu -- load/store unit; option YSYX_22041071_MISALIGN_EXC_EN
// Rev 1.0
// =====================================================================
module ysyx_22041071_lsu
   import ysyx_22041071_lsu_pkg::*;
#(
   parameter int          XLEN     = 64,
   parameter int          ADDR_W   = 64,
   parameter logic [63:0] MEM_BASE = LSU_MEM_BASE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_pc,
   input  logic [31:0]         in_ins,
   input  logic                in_ld,
   input  logic                in_st,
   input  logic                in_reg_w_en,
   input  logic [4:0]          in_rd,
   input  logic [XLEN-1:0]     in_addr,
   input  logic [XLEN-1:0]     in_wdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_W-1:0]   out_pc,
   output logic [31:0]         out_ins,
   output logic                out_reg_w_en,
   output logic [4:0]          out_rd,
   output logic [XLEN-1:0]     out_wb_data,
   output logic                out_misalign,
   output logic                fwd_reg_w_en,
   output logic [4:0]          fwd_rd,
   output logic [XLEN-1:0]     fwd_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_wen,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [XLEN-1:0]     mem_req_wdata,
   output logic [XLEN/8-1:0]   mem_req_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [XLEN-1:0]     mem_rsp_rdata
);
   localparam int NB = XLEN / 8;
   localparam int LW = $clog2(NB);

   lsu_state_t        state, state_nxt;
   logic [ADDR_W-1:0] op_pc;
   logic [31:0]       op_ins;
   logic              op_ld, op_st, op_reg_w_en;
   logic [4:0]        op_rd;
   logic [XLEN-1:0]   op_addr, op_wdata;

   logic              accept, is_mem, in_misalign, early_done, rsp_done;
   logic [XLEN-1:0]   load_data;
   logic [ADDR_W-1:0] rel_addr;

   assign in_ready   = (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign is_mem     = in_ld || in_st;
`ifdef YSYX_22041071_MISALIGN_EXC_EN
   assign in_misalign = is_mem && lsu_misaligned(in_ins[14:12], in_addr[2:0], XLEN == 64);
`else
   assign in_misalign = 1'b0;
`endif
   assign early_done = accept && (!is_mem || in_misalign);
   assign rsp_done   = (state == ST_WAIT) && mem_rsp_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept && is_mem && !in_misalign) state_nxt = ST_REQ;
         ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Captured operands keep the request stable while upstream moves on.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_pc       <= '0;
         op_ins      <= '0;
         op_ld       <= 1'b0;
         op_st       <= 1'b0;
         op_reg_w_en <= 1'b0;
         op_rd       <= '0;
         op_addr     <= '0;
         op_wdata    <= '0;
      end else if (accept) begin
         op_pc       <= in_pc;
         op_ins      <= in_ins;
         op_ld       <= in_ld;
         op_st       <= in_st;
         op_reg_w_en <= in_reg_w_en;
         op_rd       <= in_rd;
         op_addr     <= in_addr;
         op_wdata    <= in_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_ins      <= '0;
         out_reg_w_en <= 1'b0;
         out_rd       <= '0;
         out_wb_data  <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (early_done) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_ins      <= in_ins;
            out_reg_w_en <= in_reg_w_en && !in_misalign;
            out_rd       <= in_rd;
            out_wb_data  <= in_addr;
         end else if (rsp_done) begin
            out_valid    <= 1'b1;
            out_pc       <= op_pc;
            out_ins      <= op_ins;
            out_reg_w_en <= op_reg_w_en;
            out_rd       <= op_rd;
            out_wb_data  <= op_ld ? load_data : op_addr;
         end
      end
   end

`ifdef YSYX_22041071_MISALIGN_EXC_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          out_misalign <= 1'b0;
      else if (early_done) out_misalign <= in_misalign;
      else if (rsp_done)   out_misalign <= 1'b0;
   end
`else
   assign out_misalign = 1'b0;
`endif

   always_comb begin
      if (state != ST_IDLE) begin
         fwd_reg_w_en = op_reg_w_en && !op_ld;
         fwd_rd       = op_rd;
         fwd_data     = op_addr;
      end else begin
         fwd_reg_w_en = out_valid && out_reg_w_en;
         fwd_rd       = out_rd;
         fwd_data     = out_wb_data;
      end
   end

   assign rel_addr      = ADDR_W'(op_addr) - ADDR_W'(MEM_BASE);
   assign mem_req_addr  = {rel_addr[ADDR_W-1:LW], {LW{1'b0}}};
   assign mem_req_valid = (state == ST_REQ);
   assign mem_req_wen   = op_st;

   ysyx_22041071_lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .funct3    (op_ins[14:12]),
      .lane_raw  (op_addr[LW-1:0]),
      .wdata     (op_wdata),
      .rdata     (mem_rsp_rdata),
      .wstrb     (mem_req_wstrb),
      .wdata_out (mem_req_wdata),
      .rdata_out (load_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_lsu.sv
`default_nettype none
// =====================================================================
// tb_ysyx_22041071_lsu -- directed self-checking bench for the LSU
// Rev 1.0
// =====================================================================
module tb_ysyx_22041071_lsu;
   localparam int XLEN   = 64;
   localparam int ADDR_W = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready;
   logic [ADDR_W-1:0] in_pc;
   logic [31:0]       in_ins;
   logic              in_ld, in_st, in_reg_w_en;
   logic [4:0]        in_rd;
   logic [XLEN-1:0]   in_addr, in_wdata;
   logic              out_valid, out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [31:0]       out_ins;
   logic              out_reg_w_en;
   logic [4:0]        out_rd;
   logic [XLEN-1:0]   out_wb_data;
   logic              out_misalign;
   logic              fwd_reg_w_en;
   logic [4:0]        fwd_rd;
   logic [XLEN-1:0]   fwd_data;
   logic              mem_req_valid, mem_req_ready, mem_req_wen;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [XLEN-1:0]   mem_req_wdata;
   logic [XLEN/8-1:0] mem_req_wstrb;
   logic              mem_rsp_valid;
   logic [XLEN-1:0]   mem_rsp_rdata;

   int errors = 0;
   int checks = 0;

   ysyx_22041071_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_BASE(64'h8000_0000)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
      .in_ld(in_ld), .in_st(in_st), .in_reg_w_en(in_reg_w_en), .in_rd(in_rd),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
      .out_reg_w_en(out_reg_w_en), .out_rd(out_rd), .out_wb_data(out_wb_data),
      .out_misalign(out_misalign),
      .fwd_reg_w_en(fwd_reg_w_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_ins(input logic [2:0] f3);
      return {17'd0, f3, 12'h003};
   endfunction

   task automatic clear_inputs();
      in_valid = 0; in_pc = '0; in_ins = '0; in_ld = 0; in_st = 0;
      in_reg_w_en = 0; in_rd = '0; in_addr = '0; in_wdata = '0;
      out_ready = 1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
   endtask

   task automatic test_reset();
      reset = 0;
      clear_inputs();
      step();
      step();
      checks++;
      if ({out_valid, mem_req_valid, out_reg_w_en, out_misalign} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got v=%b req=%b wen=%b mis=%b want all 0",
                  out_valid, mem_req_valid, out_reg_w_en, out_misalign);
      end
      checks++;
      if ({out_pc, out_ins, out_rd, out_wb_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: got pc=%h ins=%h rd=%0d wb=%h want 0",
                  out_pc, out_ins, out_rd, out_wb_data);
      end
      reset = 1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_passthrough();
      clear_inputs();
      in_valid = 1; in_pc = 64'h8000_0100; in_ins = mk_ins(3'b000);
      in_addr = 64'h1234; in_rd = 5; in_reg_w_en = 1;
      step();
      in_valid = 0;
      checks++;
      if ({out_valid, out_wb_data, out_rd, out_reg_w_en} !== {1'b1, 64'h1234, 5'd5, 1'b1}) begin
         errors++;
         $display("FAIL pass_out: got v=%b wb=%h rd=%0d wen=%b want v=1 wb=1234 rd=5 wen=1",
                  out_valid, out_wb_data, out_rd, out_reg_w_en);
      end
      checks++;
      if (out_pc !== 64'h8000_0100) begin
         errors++;
         $display("FAIL pass_pc: got %h want 80000100", out_pc);
      end
      checks++;
      if ({fwd_reg_w_en, fwd_rd, fwd_data} !== {1'b1, 5'd5, 64'h1234}) begin
         errors++;
         $display("FAIL pass_fwd: got en=%b rd=%0d data=%h want en=1 rd=5 data=1234",
                  fwd_reg_w_en, fwd_rd, fwd_data);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pass_drain: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1;
         in_reg_w_en = 1;
         in_rd = 5'(i + 1);
         in_addr = 64'h100 * 64'(i + 1);
         step();
         checks++;
         if ({out_valid, out_wb_data, out_rd} !== {1'b1, 64'h100 * 64'(i + 1), 5'(i + 1)}) begin
            errors++;
            $display("FAIL b2b_%0d: got v=%b wb=%h rd=%0d want v=1 wb=%h rd=%0d",
                     i, out_valid, out_wb_data, out_rd, 64'h100 * 64'(i + 1), i + 1);
         end
      end
      in_valid = 0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s   [6] = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b100, 3'b110};
      logic [63:0] addrs [6] = '{64'h8000_0003, 64'h8000_000A, 64'h8000_0014,
                                 64'h8000_0018, 64'h8000_0007, 64'h8000_0000};
      logic [63:0] reqs  [6] = '{64'h0, 64'h8, 64'h10, 64'h18, 64'h0, 64'h0};
      logic [63:0] rdat  [6] = '{64'h0000_0000_8000_0000, 64'h0000_0000_F00D_0000,
                                 64'h8765_4321_0000_0000, 64'h0123_4567_89AB_CDEF,
                                 64'hA500_0000_0000_0000, 64'h0000_0000_FFFF_FFFE};
      logic [63:0] exps  [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_F00D,
                                 64'hFFFF_FFFF_8765_4321, 64'h0123_4567_89AB_CDEF,
                                 64'h0000_0000_0000_00A5, 64'h0000_0000_FFFF_FFFE};
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         in_valid = 1; in_ld = 1; in_reg_w_en = 1; in_rd = 7;
         in_ins = mk_ins(f3s[i]); in_addr = addrs[i];
         step();
         in_valid = 0;
         checks++;
         if ({mem_req_valid, mem_req_wen, in_ready, mem_req_addr} !== {3'b100, reqs[i]}) begin
            errors++;
            $display("FAIL load%0d_req: got v=%b wen=%b rdy=%b addr=%h want v=1 wen=0 rdy=0 addr=%h",
                     i, mem_req_valid, mem_req_wen, in_ready, mem_req_addr, reqs[i]);
         end
         mem_req_ready = 1;
         step();
         mem_req_ready = 0;
         checks++;
         if ({mem_req_valid, fwd_reg_w_en, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL load%0d_wait: got req=%b fwd_en=%b out_v=%b want 0 0 0",
                     i, mem_req_valid, fwd_reg_w_en, out_valid);
         end
         mem_rsp_valid = 1; mem_rsp_rdata = rdat[i];
         step();
         mem_rsp_valid = 0;
         checks++;
         if ({out_valid, out_rd, out_wb_data} !== {1'b1, 5'd7, exps[i]}) begin
            errors++;
            $display("FAIL load%0d_data: got v=%b rd=%0d wb=%h want v=1 rd=7 wb=%h",
                     i, out_valid, out_rd, out_wb_data, exps[i]);
         end
         step();
      end
   endtask

   task automatic test_store_stall();
      clear_inputs();
      in_valid = 1; in_st = 1; in_ins = mk_ins(3'b001); in_pc = 64'h8000_0200;
      in_addr = 64'h8000_0006; in_wdata = 64'hBEEF;
      step();
      in_valid = 0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({mem_req_valid, mem_req_wen, in_ready, mem_req_wstrb, mem_req_addr, mem_req_wdata}
             !== {3'b110, 8'hC0, 64'h0, 64'hBEEF_0000_0000_0000}) begin
            errors++;
            $display("FAIL store_req_c%0d: got v=%b wen=%b rdy=%b strb=%h addr=%h wd=%h want 1 1 0 c0 0 beef000000000000",
                     c, mem_req_valid, mem_req_wen, in_ready, mem_req_wstrb, mem_req_addr, mem_req_wdata);
         end
         mem_rsp_valid = (c == 1);
         step();
         mem_rsp_valid = 0;
      end
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      checks++;
      if ({out_valid, mem_req_valid, in_ready} !== 3'b000) begin
         errors++;
         $display("FAIL store_wait: got out_v=%b req=%b rdy=%b want 0 0 0",
                  out_valid, mem_req_valid, in_ready);
      end
      mem_rsp_valid = 1; mem_rsp_rdata = 64'hDEAD;
      out_ready = 0;
      step();
      mem_rsp_valid = 0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({out_valid, out_reg_w_en, in_ready, out_pc} !== {3'b100, 64'h8000_0200}) begin
            errors++;
            $display("FAIL store_hold_c%0d: got v=%b wen=%b rdy=%b pc=%h want 1 0 0 80000200",
                     c, out_valid, out_reg_w_en, in_ready, out_pc);
         end
         step();
      end
      out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL store_release: got in_ready=%b want 1", in_ready);
      end
      step();
   endtask

   task automatic test_misalign();
      clear_inputs();
      in_valid = 1; in_ld = 1; in_reg_w_en = 1; in_rd = 9;
      in_ins = mk_ins(3'b010); in_addr = 64'h8000_0002;
      step();
      in_valid = 0;
`ifdef YSYX_22041071_MISALIGN_EXC_EN
      checks++;
      if ({mem_req_valid, out_valid, out_misalign, out_reg_w_en} !== 4'b0110) begin
         errors++;
         $display("FAIL misalign_exc: got req=%b v=%b mis=%b wen=%b want 0 1 1 0",
                  mem_req_valid, out_valid, out_misalign, out_reg_w_en);
      end
      step();
      checks++;
      if (mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL misalign_noreq: got req=%b want 0", mem_req_valid);
      end
`else
      checks++;
      if ({mem_req_valid, mem_req_wstrb, mem_req_addr} !== {1'b1, 8'h0F, 64'h0}) begin
         errors++;
         $display("FAIL misalign_trunc_req: got v=%b strb=%h addr=%h want 1 0f 0",
                  mem_req_valid, mem_req_wstrb, mem_req_addr);
      end
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      mem_rsp_valid = 1; mem_rsp_rdata = 64'h0000_0000_FFFF_FFFE;
      step();
      mem_rsp_valid = 0;
      checks++;
      if ({out_valid, out_misalign, out_reg_w_en, out_wb_data} !== {3'b101, 64'hFFFF_FFFF_FFFF_FFFE}) begin
         errors++;
         $display("FAIL misalign_trunc_data: got v=%b mis=%b wen=%b wb=%h want 1 0 1 fffffffffffffffe",
                  out_valid, out_misalign, out_reg_w_en, out_wb_data);
      end
`endif
      step();
   endtask

   task automatic test_reset_in_wait();
      clear_inputs();
      in_valid = 1; in_ld = 1; in_reg_w_en = 1; in_rd = 3;
      in_ins = mk_ins(3'b011); in_addr = 64'h8000_0000;
      step();
      in_valid = 0;
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      reset = 0;
      step();
      reset = 1;
      #1;
      mem_rsp_valid = 1; mem_rsp_rdata = 64'h5555;
      step();
      mem_rsp_valid = 0;
      checks++;
      if ({out_valid, in_ready, mem_req_valid} !== 3'b010) begin
         errors++;
         $display("FAIL reset_wait: got out_v=%b rdy=%b req=%b want 0 1 0",
                  out_valid, in_ready, mem_req_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_wait_late: got out_valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_back_to_back();
      test_loads();
      test_store_stall();
      test_misalign();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_22041071_lsu.md
YSYX_22041071_LSU -- requirements
Module: ysyx_22041071_lsu

Interface
REQ-001 Parameters SHALL be: XLEN, default 64, data width (32 or 64); ADDR_W, default 64, address width; MEM_BASE, default 64'h8000_0000, subtracted from every memory address.
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 Port reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 Ports in_valid in 1 / in_ready out 1 SHALL form the upstream handshake; a transfer occurs when both are 1.
REQ-005 Ports in_pc in ADDR_W and in_ins in 32 SHALL carry the instruction PC and word; funct3 is in_ins[14:12].
REQ-006 Ports in_ld in 1 and in_st in 1 SHALL mark load and store ops; both 0 means pass-through.
REQ-007 Ports in_reg_w_en in 1, in_rd in 5, in_addr in XLEN and in_wdata in XLEN SHALL carry the write-back control, the ALU result/effective address and the store data.
REQ-008 Ports out_valid out 1 / out_ready in 1 SHALL form the downstream handshake.
REQ-009 Ports out_pc, out_ins, out_reg_w_en, out_rd, out_wb_data (XLEN) and out_misalign (1) SHALL all be registered outputs.
REQ-010 Ports fwd_reg_w_en, fwd_rd and fwd_data SHALL be combinational bypass outputs of the op currently in flight; fwd_reg_w_en=0 while a load is pending.
REQ-011 Ports mem_req_valid out 1, mem_req_ready in 1, mem_req_wen out 1, mem_req_addr out ADDR_W (lane-aligned, base-relative), mem_req_wdata out XLEN and mem_req_wstrb out XLEN/8 SHALL form the memory request channel.
REQ-012 Ports mem_rsp_valid in 1 and mem_rsp_rdata in XLEN SHALL form the response channel; one response per request, for loads and stores alike.

Function
REQ-013 The FSM SHALL have states IDLE, REQ and WAIT; in_ready=1 only in IDLE and when (!out_valid || out_ready).
REQ-014 A pass-through op SHALL appear on the outputs one cycle after acceptance (out_wb_data=in_addr), giving throughput 1/cycle under back-to-back accept with out_ready=1.
REQ-015 A memory op SHALL go IDLE->REQ; mem_req_valid=1 and all request fields SHALL stay stable in REQ until mem_req_ready; REQ->WAIT on mem_req_ready.
REQ-016 In WAIT, mem_rsp_valid SHALL load the output register, set out_valid and return to IDLE; mem_rsp_valid in IDLE or REQ SHALL be ignored.
REQ-017 Byte lane L=addr[log2(XLEN/8)-1:0]; wstrb SHALL be size-mask<<L and wdata SHALL be in_wdata<<(8*L) for sb/sh/sw/sd.
REQ-018 Load data SHALL be rdata>>(8*L), sign-extended for lb/lh/lw and zero-extended for lbu/lhu/lwu; ld returns full XLEN.
REQ-019 An access SHALL be misaligned when its address is not a multiple of its size; ld/lwu/sd with XLEN=32 SHALL be treated as misaligned.
REQ-020 While out_valid=1 and out_ready=0, all out_* SHALL hold their values.

Reset
REQ-021 On reset low, the state SHALL become IDLE and out_valid, mem_req_valid, out_reg_w_en and out_misalign SHALL go to 0; out_rd, out_ins and out_wb_data SHALL go to 0 and out_pc to 0.
REQ-022 A reset asserted in REQ or WAIT SHALL abandon the access; a response that arrives afterwards SHALL be ignored (REQ-016).

Configuration
REQ-023 With YSYX_22041071_MISALIGN_EXC_EN defined, a misaligned op SHALL issue no request and SHALL complete one cycle later with out_misalign=1 and out_reg_w_en=0.
REQ-024 Without YSYX_22041071_MISALIGN_EXC_EN, out_misalign SHALL be tied to 0 and the address low bits SHALL be truncated to size alignment, with the access proceeding normally.

Structure
REQ-025 The shared package SHALL hold the funct3 load/store encodings, the FSM state encoding and the MEM_BASE default.
REQ-026 Lane shift, strobe generation and load extension SHALL live in the combinational sub-module ysyx_22041071_lsu_align.

Verification
REQ-027 Pass-through: in_addr=64'h1234, rd=5, out_ready=1 -> next cycle out_valid=1, out_wb_data=64'h1234, out_rd=5.
REQ-028 lb at 8000_0003 with rdata=64'h0000_0000_8000_0000 -> mem_req_addr=0, out_wb_data=64'hFFFF_FFFF_FFFF_FF80.
REQ-029 sh at 8000_0006 with wdata=16'hBEEF -> wstrb=8'hC0, mem_req_wdata=64'hBEEF_0000_0000_0000, mem_req_wen=1.
REQ-030 mem_req_ready held 0 for 3 cycles and out_ready held 0 for 2 cycles after the response -> request fields and outputs stable, in_ready=0 throughout.
REQ-031 MISALIGN_EXC_EN defined, lw at 8000_0002 -> no mem_req_valid, out_misalign=1, out_reg_w_en=0.
REQ-032 Reset pulsed in WAIT, then mem_rsp_valid=1 -> out_valid stays 0, state IDLE, in_ready=1.
